if_fetch_unit: RTL and testbench

- Instruction-fetch stage; the producer side of the IF/ID interface.
- Holds the PC, runs a single-outstanding request/acknowledge handshake to instruction memory, and presents if_pc/if_inst/if_valid to the IF/ID register.
- Honours pipeline stalls, MIPS branches with delay slot (redirect applied after the delay slot), and exception flushes that discard in-flight fetches.

---
 rtl/if_fetch_unit_if.sv | 24 ++
 rtl/if_fetch_unit.sv | 127 ++++++++++++
 tb/tb_if_fetch_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory handshake plus IF/ID presentation signals of the fetch stage.
// master = fetch unit, slave = memory / IF-ID register side.
interface if_fetch_unit_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              inst_req;
   logic [ADDR_W-1:0] inst_addr;
   logic              inst_ack;
   logic [DATA_W-1:0] inst_rdata;
   logic [ADDR_W-1:0] if_pc;
   logic [DATA_W-1:0] if_inst;
   logic              if_valid;

   modport master (
      output inst_req, inst_addr, if_pc, if_inst, if_valid,
      input  inst_ack, inst_rdata
   );

   modport slave (
      input  inst_req, inst_addr, if_pc, if_inst, if_valid,
      output inst_ack, inst_rdata
   );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding memory handshake, IF/ID presentation,
// branch delay-slot redirect and exception flush.
module if_fetch_unit #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              stall_aluop_i,
   input  logic              branch_flag_i,
   input  logic [ADDR_W-1:0] branch_target_i,
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] flush_pc_i,
   if_fetch_unit_if.master   bus_io
);

   localparam logic [1:0] S_FETCH = 2'd0;
   localparam logic [1:0] S_OUT   = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;

   logic [1:0]        state_q,       state_d;
   logic [ADDR_W-1:0] pc_q,          pc_d;
   logic [ADDR_W-1:0] kill_addr_q,   kill_addr_d;
   logic              pend_valid_q,  pend_valid_d;
   logic [ADDR_W-1:0] pend_target_q, pend_target_d;
   logic [ADDR_W-1:0] if_pc_q,       if_pc_d;
   logic [DATA_W-1:0] if_inst_q,     if_inst_d;
   logic              if_valid_q,    if_valid_d;

   logic stall_any;
   logic consume;

   assign stall_any = stall_i | stall_aluop_i;
   assign consume   = (state_q == S_OUT) && !stall_any;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      kill_addr_d   = kill_addr_q;
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;
      if_pc_d       = if_pc_q;
      if_inst_d     = if_inst_q;
      if_valid_d    = if_valid_q;

      if (flush_i) begin
         pend_valid_d = 1'b0;
         pc_d         = flush_pc_i;
         if_valid_d   = 1'b0;
         case (state_q)
            S_OUT:   state_d = S_FETCH;
            S_FETCH: begin
               // Unacked request stays outstanding; remember its address to keep the bus stable.
               if (bus_io.inst_ack) begin
                  state_d = S_FETCH;
               end else begin
                  state_d     = S_FLUSH;
                  kill_addr_d = pc_q;
               end
            end
            S_FLUSH: state_d = bus_io.inst_ack ? S_FETCH : S_FLUSH;
            default: state_d = S_FETCH;
         endcase
      end else begin
         case (state_q)
            S_FETCH: begin
               if (bus_io.inst_ack) begin
                  if_pc_d    = pc_q;
                  if_inst_d  = bus_io.inst_rdata;
                  if_valid_d = 1'b1;
                  state_d    = S_OUT;
               end
            end
            S_OUT: begin
               if (!stall_any) begin
                  if_valid_d   = 1'b0;
                  state_d      = S_FETCH;
                  pend_valid_d = 1'b0;
                  if (branch_flag_i)     pc_d = branch_target_i;
                  else if (pend_valid_q) pc_d = pend_target_q;
                  else                   pc_d = pc_q + ADDR_W'(4);
               end
            end
            S_FLUSH: begin
               if (bus_io.inst_ack) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
         endcase

         if (branch_flag_i && !consume) begin
            pend_valid_d  = 1'b1;
            pend_target_d = branch_target_i;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_FETCH;
         pc_q          <= RESET_PC;
         kill_addr_q   <= RESET_PC;
         pend_valid_q  <= 1'b0;
         pend_target_q <= '0;
         if_pc_q       <= RESET_PC;
         if_inst_q     <= '0;
         if_valid_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         kill_addr_q   <= kill_addr_d;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
         if_pc_q       <= if_pc_d;
         if_inst_q     <= if_inst_d;
         if_valid_q    <= if_valid_d;
      end
   end

   assign bus_io.inst_req  = !rst && (state_q != S_OUT);
   assign bus_io.inst_addr = (state_q == S_FLUSH) ? kill_addr_q : pc_q;
   assign bus_io.if_pc     = if_pc_q;
   assign bus_io.if_inst   = if_inst_q;
   assign bus_io.if_valid  = if_valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed per-cycle vectors for if_fetch_unit followed by a wait-state fetch sequence.
module tb_if_fetch_unit;

   localparam logic [31:0] R = 32'hBFC0_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0, stall_aluop = 1'b0, branch_flag = 1'b0, flush = 1'b0;
   logic [31:0] branch_target = '0, flush_pc = '0;

   int unsigned errors = 0;
   int unsigned checks = 0;

   if_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   if_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hBFC0_0000)) dut (
      .clk             (clk),
      .rst             (rst),
      .stall_i         (stall),
      .stall_aluop_i   (stall_aluop),
      .branch_flag_i   (branch_flag),
      .branch_target_i (branch_target),
      .flush_i         (flush),
      .flush_pc_i      (flush_pc),
      .bus_io          (bus.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, stl, alu, br;
      logic [31:0] bt;
      logic        fl;
      logic [31:0] fpc;
      logic        ack;
      logic [31:0] rd;
      logic        req;
      logic [31:0] addr;
      logic        vld;
      logic [31:0] pc, inst;
   } vec_t;

   vec_t vecs[$];

   task automatic v(input logic r, s, a, b, input logic [31:0] bt, input logic f,
                    input logic [31:0] fpc, input logic ack, input logic [31:0] rd,
                    input logic req, input logic [31:0] addr, input logic vld,
                    input logic [31:0] pc, input logic [31:0] inst);
      vec_t t;
      t.rst = r; t.stl = s; t.alu = a; t.br = b; t.bt = bt; t.fl = f; t.fpc = fpc;
      t.ack = ack; t.rd = rd; t.req = req; t.addr = addr; t.vld = vld; t.pc = pc; t.inst = inst;
      vecs.push_back(t);
   endtask

   task automatic check(input string name, input logic req, input logic [31:0] addr,
                        input logic vld, input logic [31:0] pc, input logic [31:0] inst);
      checks++;
      if (bus.inst_req !== req || bus.inst_addr !== addr || bus.if_valid !== vld ||
          bus.if_pc !== pc || bus.if_inst !== inst) begin
         errors++;
         $display("FAIL %s got req=%b addr=%h vld=%b pc=%h inst=%h exp req=%b addr=%h vld=%b pc=%h inst=%h",
                  name, bus.inst_req, bus.inst_addr, bus.if_valid, bus.if_pc, bus.if_inst,
                  req, addr, vld, pc, inst);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_addr;
      logic [31:0] data;
      bus.inst_ack   = 1'b0;
      bus.inst_rdata = '0;

      //  rst s a b  bt         f  fpc        ack rd          req addr        vld pc          inst
      v(1,0,0,0, 0,          0, 0,          0, 0,           0, R,          0, R,          0);
      v(1,0,0,0, 0,          0, 0,          0, 0,           0, R,          0, R,          0);
      v(0,0,0,0, 0,          0, 0,          1, 32'h11111111, 1, R,          0, R,          0);
      v(0,0,0,0, 0,          0, 0,          0, 0,           0, R,          1, R,          32'h11111111);
      v(0,0,0,0, 0,          0, 0,          1, 32'h22222222, 1, R+4,        0, R,          32'h11111111);
      v(0,1,0,0, 0,          0, 0,          0, 0,           0, R+4,        1, R+4,        32'h22222222);
      v(0,0,1,0, 0,          0, 0,          0, 0,           0, R+4,        1, R+4,        32'h22222222);
      v(0,1,1,0, 0,          0, 0,          0, 0,           0, R+4,        1, R+4,        32'h22222222);
      v(0,1,0,0, 0,          0, 0,          0, 0,           0, R+4,        1, R+4,        32'h22222222);
      v(0,0,1,0, 0,          0, 0,          0, 0,           0, R+4,        1, R+4,        32'h22222222);
      v(0,0,0,0, 0,          0, 0,          0, 0,           0, R+4,        1, R+4,        32'h22222222);
      v(0,0,0,0, 0,          0, 0,          0, 0,           1, R+8,        0, R+4,        32'h22222222);
      v(0,0,0,0, 0,          0, 0,          1, 32'h33333333, 1, R+8,        0, R+4,        32'h22222222);
      v(0,0,0,0, 0,          0, 0,          0, 0,           0, R+8,        1, R+8,        32'h33333333);
      v(0,0,0,0, 0,          1, 32'h100,    0, 0,           1, R+12,       0, R+8,        32'h33333333);
      v(0,0,0,0, 0,          0, 0,          1, 32'hDEADBEEF, 1, R+12,       0, R+8,        32'h33333333);
      v(0,0,0,0, 0,          0, 0,          1, 32'hA0000100, 1, 32'h100,    0, R+8,        32'h33333333);
      v(0,0,0,0, 0,          0, 0,          0, 0,           0, 32'h100,    1, 32'h100,    32'hA0000100);
      v(0,0,0,1, 32'h400,    0, 0,          0, 0,           1, 32'h104,    0, 32'h100,    32'hA0000100);
      v(0,0,0,0, 0,          0, 0,          1, 32'hA0000104, 1, 32'h104,    0, 32'h100,    32'hA0000100);
      v(0,0,0,0, 0,          0, 0,          0, 0,           0, 32'h104,    1, 32'h104,    32'hA0000104);
      v(0,0,0,0, 0,          0, 0,          1, 32'hA0000400, 1, 32'h400,    0, 32'h104,    32'hA0000104);
      v(0,0,0,0, 0,          0, 0,          0, 0,           0, 32'h400,    1, 32'h400,    32'hA0000400);
      v(0,0,0,0, 0,          0, 0,          1, 32'hB0000404, 1, 32'h404,    0, 32'h400,    32'hA0000400);
      v(0,0,0,0, 0,          0, 0,          0, 0,           0, 32'h404,    1, 32'h404,    32'hB0000404);
      v(0,0,0,0, 0,          0, 0,          1, 32'hB0000408, 1, 32'h408,    0, 32'h404,    32'hB0000404);
      v(0,0,0,1, 32'h600,    0, 0,          0, 0,           0, 32'h408,    1, 32'h408,    32'hB0000408);
      v(0,0,0,0, 0,          0, 0,          1, 32'hB0000600, 1, 32'h600,    0, 32'h408,    32'hB0000408);
      v(0,0,0,0, 0,          0, 0,          0, 0,           0, 32'h600,    1, 32'h600,    32'hB0000600);
      v(0,0,0,0, 0,          0, 0,          1, 32'hC0000604, 1, 32'h604,    0, 32'h600,    32'hB0000600);
      v(0,1,0,1, 32'h700,    0, 0,          0, 0,           0, 32'h604,    1, 32'h604,    32'hC0000604);
      v(0,1,0,1, 32'h800,    0, 0,          0, 0,           0, 32'h604,    1, 32'h604,    32'hC0000604);
      v(0,0,0,0, 0,          0, 0,          0, 0,           0, 32'h604,    1, 32'h604,    32'hC0000604);
      v(0,0,0,0, 0,          1, 32'h200,    1, 32'hDEAD0000, 1, 32'h800,    0, 32'h604,    32'hC0000604);
      v(0,0,0,0, 0,          0, 0,          0, 0,           1, 32'h200,    0, 32'h604,    32'hC0000604);
      v(0,0,0,0, 0,          1, 32'h80000180, 0, 0,         1, 32'h200,    0, 32'h604,    32'hC0000604);
      v(0,0,0,0, 0,          0, 0,          0, 0,           1, 32'h200,    0, 32'h604,    32'hC0000604);
      v(0,0,0,0, 0,          0, 0,          0, 0,           1, 32'h200,    0, 32'h604,    32'hC0000604);
      v(0,0,0,0, 0,          0, 0,          1, 32'hDEAD0200, 1, 32'h200,    0, 32'h604,    32'hC0000604);
      v(0,0,0,0, 0,          0, 0,          1, 32'h11110180, 1, 32'h80000180, 0, 32'h604,  32'hC0000604);
      v(0,1,0,1, 32'h900,    0, 0,          0, 0,           0, 32'h80000180, 1, 32'h80000180, 32'h11110180);
      v(0,1,0,1, 32'hA00,    1, 32'h300,    0, 0,           0, 32'h80000180, 1, 32'h80000180, 32'h11110180);
      v(0,0,0,0, 0,          0, 0,          1, 32'h22220300, 1, 32'h300,    0, 32'h80000180, 32'h11110180);
      v(0,0,0,0, 0,          0, 0,          0, 0,           0, 32'h300,    1, 32'h300,    32'h22220300);
      v(0,0,0,0, 0,          1, 32'h500,    0, 0,           1, 32'h304,    0, 32'h300,    32'h22220300);
      v(1,0,0,0, 0,          0, 0,          0, 0,           0, R,          0, R,          0);
      v(0,0,0,0, 0,          0, 0,          0, 0,           1, R,          0, R,          0);
      v(0,0,0,0, 0,          0, 0,          1, 32'h12345678, 1, R,          0, R,          0);
      v(0,1,0,0, 0,          0, 0,          0, 0,           0, R,          1, R,          32'h12345678);
      v(1,1,0,0, 0,          0, 0,          0, 0,           0, R,          0, R,          0);
      v(0,0,0,0, 0,          1, 32'hFFFFFFFC, 1, 32'h00000001, 1, R,       0, R,          0);
      v(0,0,0,0, 0,          0, 0,          1, 32'h5555FFFC, 1, 32'hFFFFFFFC, 0, R,        0);
      v(0,0,0,0, 0,          0, 0,          0, 0,           0, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 32'h5555FFFC);
      v(0,0,0,0, 0,          0, 0,          0, 0,           1, 32'h00000000, 0, 32'hFFFFFFFC, 32'h5555FFFC);

      foreach (vecs[i]) begin
         @(negedge clk);
         rst            = vecs[i].rst;
         stall          = vecs[i].stl;
         stall_aluop    = vecs[i].alu;
         branch_flag    = vecs[i].br;
         branch_target  = vecs[i].bt;
         flush          = vecs[i].fl;
         flush_pc       = vecs[i].fpc;
         bus.inst_ack   = vecs[i].ack;
         bus.inst_rdata = vecs[i].rd;
         #1;
         check($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].vld,
               vecs[i].pc, vecs[i].inst);
      end

      // Wait-state fetches continuing from address 0: address must stay put until ack.
      exp_addr = 32'h0;
      data     = 32'hFFFFFFFC;
      for (int k = 0; k < 3; k++) begin
         logic [31:0] prev_pc;
         logic [31:0] prev_inst;
         prev_pc   = (k == 0) ? 32'hFFFFFFFC : exp_addr - 32'd4;
         prev_inst = (k == 0) ? 32'h5555FFFC : data;
         for (int w = 0; w <= k; w++) begin
            @(negedge clk);
            bus.inst_ack = 1'b0;
            #1;
            check($sformatf("wait%0d_%0d", k, w), 1'b1, exp_addr, 1'b0, prev_pc, prev_inst);
         end
         data = 32'hC0DE0000 | exp_addr;
         @(negedge clk);
         bus.inst_ack   = 1'b1;
         bus.inst_rdata = data;
         #1;
         check($sformatf("ack%0d", k), 1'b1, exp_addr, 1'b0, prev_pc, prev_inst);
         @(negedge clk);
         bus.inst_ack = 1'b0;
         #1;
         check($sformatf("present%0d", k), 1'b0, exp_addr, 1'b1, exp_addr, data);
         exp_addr = exp_addr + 32'd4;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
